// File: rtl/traffic_pkg.sv
// Shared encodings for the traffic-light controller and its front-end blocks.
// Contents:
//   ctrl_state_e : controller state reported on the controller's `state` output
//   phase_e      : vehicle_request FSM phase, exported on its `phase` port
package traffic_pkg;

  typedef enum logic [1:0] {
    S_MG = 2'd0,  // main green
    S_MY = 2'd1,  // main yellow
    S_CG = 2'd2,  // country green
    S_CY = 2'd3   // country yellow
  } ctrl_state_e;

  typedef enum logic [1:0] {
    PH_IDLE  = 2'd0,
    PH_WAIT  = 2'd1,
    PH_SERVE = 2'd2
  } phase_e;

endpackage

// File: rtl/det_debounce.sv
// Detector conditioning: 2-FF synchronizer, level debouncer, rising-edge detect.
// Ports:
//   clk     in  : system clock
//   rst     in  : synchronous active-low reset
//   det_raw in  : raw asynchronous, bouncy detector level
//   rise    out : high for one cycle after the debounced level goes 0->1
// A level change is accepted on the DEB_CYC-th consecutive cycle on which the
// synchronized input differs from the debounced level.
module det_debounce #(
  parameter int DEB_CYC = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic det_raw,
  output logic rise
);

  localparam int CW = (DEB_CYC > 1) ? $clog2(DEB_CYC + 1) : 1;

  logic          sync1_r;
  logic          sync2_r;
  logic          db_r;
  logic          db_d_r;
  logic [CW-1:0] cnt_r;

  // Synchronizer, debounce counter and debounced-level history.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      db_r    <= 1'b0;
      db_d_r  <= 1'b0;
      cnt_r   <= '0;
    end else begin
      sync1_r <= det_raw;
      sync2_r <= sync1_r;
      db_d_r  <= db_r;
      if (sync2_r == db_r) begin
        cnt_r <= '0;
      end else if (cnt_r == CW'(DEB_CYC - 1)) begin
        // This sample is the DEB_CYC-th consecutive mismatch: accept it.
        db_r  <= sync2_r;
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + CW'(1);
      end
    end
  end

  assign rise = db_r & ~db_d_r;

endmodule

// File: rtl/vehicle_request.sv
// Country-road vehicle request front end for the traffic-light controller.
// Ports:
//   clk       in        : system clock (shared with the controller)
//   rst       in        : synchronous active-low reset
//   det_raw   in        : raw detector level, active high, asynchronous
//   state     in  [1:0] : controller state (traffic_pkg::ctrl_state_e)
//   S         out       : request to controller, high while queue is nonzero
//   queue     out [QW]  : number of waiting vehicles, saturating at QMAX
//   det_pulse out       : one-cycle pulse per accepted arrival
//   ovf       out       : sticky, set when an arrival is dropped at QMAX
//   phase     out [1:0] : FSM phase (traffic_pkg::phase_e)
module vehicle_request
  import traffic_pkg::*;
#(
  parameter int DEB_CYC  = 1_000_000,
  parameter int TICK_CYC = 50_000_000,
  parameter int QMAX     = 15,
  parameter int QW       = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          det_raw,
  input  logic [1:0]    state,
  output logic          S,
  output logic [QW-1:0] queue,
  output logic          det_pulse,
  output logic          ovf,
  output logic [1:0]    phase
);

  localparam int TW = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;

  logic          arrival_s;
  logic          tick_s;
  logic [QW-1:0] queue_r;
  logic [QW-1:0] queue_nxt_s;
  logic          ovf_r;
  logic          ovf_nxt_s;
  logic          pulse_r;
  logic [TW-1:0] tmr_r;
  logic [TW-1:0] tmr_nxt_s;
  phase_e        phase_r;
  phase_e        phase_nxt_s;

  det_debounce #(
    .DEB_CYC (DEB_CYC)
  ) u_det (
    .clk     (clk),
    .rst     (rst),
    .det_raw (det_raw),
    .rise    (arrival_s)
  );

  // Departure timer next value; it only advances while serving.
  always_comb begin
    tick_s    = 1'b0;
    tmr_nxt_s = '0;
    if (phase_r == PH_SERVE) begin
      if (tmr_r == TW'(TICK_CYC - 1)) begin
        tick_s    = 1'b1;
        tmr_nxt_s = '0;
      end else begin
        tmr_nxt_s = tmr_r + TW'(1);
      end
    end else begin
      tmr_nxt_s = '0;
    end
  end

  // Queue arithmetic: arrival adds, tick removes, both together cancel
  // except that an empty queue still takes the arriving vehicle.
  always_comb begin
    queue_nxt_s = queue_r;
    ovf_nxt_s   = ovf_r;
    case ({arrival_s, tick_s})
      2'b10: begin
        if (queue_r == QW'(QMAX)) begin
          ovf_nxt_s = 1'b1;
        end else begin
          queue_nxt_s = queue_r + QW'(1);
        end
      end
      2'b01: begin
        if (queue_r != '0) begin
          queue_nxt_s = queue_r - QW'(1);
        end else begin
          queue_nxt_s = queue_r;
        end
      end
      2'b11: begin
        if (queue_r == '0) begin
          queue_nxt_s = QW'(1);
        end else begin
          queue_nxt_s = queue_r;
        end
      end
      default: begin
        queue_nxt_s = queue_r;
      end
    endcase
  end

  // Phase next-state: country green always means SERVE; otherwise the
  // queue decides between WAIT and IDLE, and WAIT is only left via SERVE.
  always_comb begin
    phase_nxt_s = phase_r;
    case (phase_r)
      PH_IDLE: begin
        if (state == S_CG) begin
          phase_nxt_s = PH_SERVE;
        end else if (queue_r != '0) begin
          phase_nxt_s = PH_WAIT;
        end else begin
          phase_nxt_s = PH_IDLE;
        end
      end
      PH_WAIT: begin
        if (state == S_CG) begin
          phase_nxt_s = PH_SERVE;
        end else begin
          phase_nxt_s = PH_WAIT;
        end
      end
      PH_SERVE: begin
        if (state == S_CG) begin
          phase_nxt_s = PH_SERVE;
        end else if (queue_r != '0) begin
          phase_nxt_s = PH_WAIT;
        end else begin
          phase_nxt_s = PH_IDLE;
        end
      end
      default: begin
        phase_nxt_s = PH_IDLE;
      end
    endcase
  end

  // State registers for queue, overflow flag, pulse, timer and phase.
  always_ff @(posedge clk) begin
    if (!rst) begin
      queue_r <= '0;
      ovf_r   <= 1'b0;
      pulse_r <= 1'b0;
      tmr_r   <= '0;
      phase_r <= PH_IDLE;
    end else begin
      queue_r <= queue_nxt_s;
      ovf_r   <= ovf_nxt_s;
      pulse_r <= arrival_s;
      tmr_r   <= tmr_nxt_s;
      phase_r <= phase_nxt_s;
    end
  end

  assign queue     = queue_r;
  assign S         = (queue_r != '0);
  assign det_pulse = pulse_r;
  assign ovf       = ovf_r;
  assign phase     = phase_r;

endmodule
